// File: rtl/efc_transition_scheduler.sv
// rtl/efc_transition_scheduler.sv - transition enable, t0/t1 round-robin choice and fire strobes for the three-FSM free-choice net
// Also tracks the hidden FSM2 branch, counts net cycles and raises sticky watchdog/marking flags.
module efc_transition_scheduler #(
  parameter int WDOG_CYCLES = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             f1_p0,
  input  logic             f1_p2,
  input  logic             f1_p4,
  input  logic             f1_p6,
  input  logic             f2_p0,
  input  logic             f2_p7,
  input  logic             f3_p1,
  input  logic             f3_p2,
  input  logic             f3_p4,
  input  logic             f3_p6,
  input  logic [6:0]       req_t,
  output logic [6:0]       t_fire,
  output logic [CNT_W-1:0] net_cycle_count,
  output logic             deadlock,
  output logic             err_marking
);

  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYCLES);

  logic            rr_ptr;
  logic            branch;
  logic [WD_W-1:0] wdog_cnt;
  logic [WD_W-1:0] wdog_next;
  logic [6:0]      en;
  logic [6:0]      cand;
  logic [6:0]      fire_d;
  logic            rr_toggle;
  logic            f2_in_mid;
  logic            bad_marking;
  logic            gated;

  function automatic logic one_hot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  always_comb begin
    f2_in_mid   = ~f2_p0 & ~f2_p7;
    en[0]       = f1_p0 & f2_p0 & f3_p1;
    en[1]       = f1_p0 & f2_p0 & f3_p1;
    en[2]       = f1_p2 & f3_p2;
    en[3]       = f2_in_mid & ~branch;
    en[4]       = f1_p4 & f3_p4;
    en[5]       = f2_in_mid & branch;
    en[6]       = f1_p6 & f2_p7 & f3_p6;
    cand        = req_t & en;
    bad_marking = ~one_hot4({f1_p0, f1_p2, f1_p4, f1_p6}) |
                  ~one_hot4({f3_p1, f3_p2, f3_p4, f3_p6}) |
                  (f2_p0 & f2_p7);
    // Place inputs are stale during a strobe, and a bad marking blocks firing in the same cycle it is flagged.
    gated       = (t_fire != 7'd0) | err_marking | bad_marking;
  end

  always_comb begin
    fire_d    = 7'd0;
    rr_toggle = 1'b0;
    if (!gated) begin
      fire_d[6:2] = cand[6:2];
      if (cand[0] & cand[1]) begin
        if (rr_ptr) fire_d[1] = 1'b1;
        else        fire_d[0] = 1'b1;
        rr_toggle = 1'b1;
      end else begin
        fire_d[1:0] = cand[1:0];
      end
    end
  end

  always_comb begin
    wdog_next = wdog_cnt;
    if ((t_fire != 7'd0) || (fire_d != 7'd0) || (req_t == 7'd0))
      wdog_next = '0;
    else if (wdog_cnt != WD_MAX)
      wdog_next = wdog_cnt + WD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_fire          <= 7'd0;
      rr_ptr          <= 1'b0;
      branch          <= 1'b0;
      wdog_cnt        <= '0;
      net_cycle_count <= '0;
      deadlock        <= 1'b0;
      err_marking     <= 1'b0;
    end else begin
      t_fire          <= fire_d;
      wdog_cnt        <= wdog_next;
      net_cycle_count <= net_cycle_count + CNT_W'(t_fire[6]);
      if (rr_toggle) rr_ptr <= ~rr_ptr;
      // Mirrors the choice FSM2 makes internally so t3/t5 can be told apart while it sits in p3/p5.
      if (fire_d[0])      branch <= 1'b0;
      else if (fire_d[1]) branch <= 1'b1;
      if (wdog_next == WD_MAX) deadlock <= 1'b1;
      if (bad_marking) err_marking <= 1'b1;
    end
  end

endmodule

// File: tb/tb_efc_transition_scheduler.sv
// tb/tb_efc_transition_scheduler.sv - directed and random checks of efc_transition_scheduler against a net-level model
module tb_efc_transition_scheduler;

  localparam int WDOG = 8;

  logic        clk;
  logic        reset;
  logic [6:0]  req_t;
  logic [6:0]  t_fire;
  logic [15:0] net_cycle_count;
  logic        deadlock;
  logic        err_marking;
  logic        f1_p0, f1_p2, f1_p4, f1_p6, f2_p0, f2_p7, f3_p1, f3_p2, f3_p4, f3_p6;

  // Environment net marking: FSM1 in {0,2,4,6}, FSM2 in {0,3,5,7}, FSM3 in {1,2,4,6}.
  int   f1s, f2s, f3s;
  logic inj;

  assign f1_p0 = (f1s == 0);
  assign f1_p2 = (f1s == 2) | inj;
  assign f1_p4 = (f1s == 4) | inj;
  assign f1_p6 = (f1s == 6);
  assign f2_p0 = (f2s == 0);
  assign f2_p7 = (f2s == 7);
  assign f3_p1 = (f3s == 1);
  assign f3_p2 = (f3s == 2);
  assign f3_p4 = (f3s == 4);
  assign f3_p6 = (f3s == 6);

  logic [6:0]  m_fire;
  logic        m_rr, m_branch, m_err, m_dead;
  int          m_wd;
  logic [15:0] m_cnt;
  int          errors, checks;

  efc_transition_scheduler #(.WDOG_CYCLES(WDOG), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .f1_p0(f1_p0), .f1_p2(f1_p2), .f1_p4(f1_p4), .f1_p6(f1_p6),
    .f2_p0(f2_p0), .f2_p7(f2_p7),
    .f3_p1(f3_p1), .f3_p2(f3_p2), .f3_p4(f3_p4), .f3_p6(f3_p6),
    .req_t(req_t), .t_fire(t_fire), .net_cycle_count(net_cycle_count),
    .deadlock(deadlock), .err_marking(err_marking)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [6:0] rq);
    logic [6:0] en, c, nf;
    logic       bad, mid;
    int         n1, n2, n3;
    reset = r;
    req_t = rq;
    #1;
    bad = ($countones({f1_p0, f1_p2, f1_p4, f1_p6}) != 1) ||
          ($countones({f3_p1, f3_p2, f3_p4, f3_p6}) != 1) || (f2_p0 && f2_p7);
    n1 = f1s; n2 = f2s; n3 = f3s;
    if (r) begin
      n1 = 0; n2 = 0; n3 = 1;
      m_fire = 0; m_rr = 0; m_branch = 0; m_err = 0; m_dead = 0; m_wd = 0; m_cnt = 0;
    end else begin
      if (m_fire[0]) begin n1 = 2; n2 = 3; n3 = 2; end
      if (m_fire[1]) begin n1 = 2; n2 = 5; n3 = 2; end
      if (m_fire[2]) begin n1 = 4; n3 = 4; end
      if (m_fire[3] || m_fire[5]) n2 = 7;
      if (m_fire[4]) begin n1 = 6; n3 = 6; end
      if (m_fire[6]) begin n1 = 0; n2 = 0; n3 = 1; end
      mid   = !f2_p0 && !f2_p7;
      en[0] = f1_p0 && f2_p0 && f3_p1;
      en[1] = en[0];
      en[2] = f1_p2 && f3_p2;
      en[3] = mid && !m_branch;
      en[4] = f1_p4 && f3_p4;
      en[5] = mid && m_branch;
      en[6] = f1_p6 && f2_p7 && f3_p6;
      c  = rq & en;
      nf = 0;
      if (m_fire == 0 && !m_err && !bad) begin
        nf = c & 7'b1111100;
        if (c[0] && c[1]) begin
          nf[m_rr] = 1'b1;
          m_rr = !m_rr;
        end else begin
          nf[1:0] = c[1:0];
        end
      end
      if (nf[0]) m_branch = 0;
      else if (nf[1]) m_branch = 1;
      if (m_fire[6]) m_cnt = m_cnt + 16'd1;
      if (m_fire != 0 || nf != 0 || rq == 0) m_wd = 0;
      else if (m_wd < WDOG) m_wd++;
      if (m_wd >= WDOG) m_dead = 1;
      if (bad) m_err = 1;
      m_fire = nf;
    end
    @(posedge clk);
    #1;
    f1s = n1; f2s = n2; f3s = n3;
    chk("model_t_fire", 32'(t_fire), 32'(m_fire));
    chk("model_count", 32'(net_cycle_count), 32'(m_cnt));
    chk("model_deadlock", 32'(deadlock), 32'(m_dead));
    chk("model_err", 32'(err_marking), 32'(m_err));
  endtask

  initial begin
    clk = 0; reset = 1; req_t = 0; inj = 0;
    f1s = 0; f2s = 0; f3s = 1;
    m_fire = 0; m_rr = 0; m_branch = 0; m_err = 0; m_dead = 0; m_wd = 0; m_cnt = 0;
    errors = 0; checks = 0;
    #1;

    step(1, 0); step(1, 0);
    chk("rst_t_fire", 32'(t_fire), 0);
    chk("rst_count", 32'(net_cycle_count), 0);
    chk("rst_deadlock", 32'(deadlock), 0);
    chk("rst_err", 32'(err_marking), 0);

    // Single t0, then t2+t3 together with t5 requested; branch=0 must suppress t5.
    step(0, 7'b0000001);
    chk("t0_strobe", 32'(t_fire), 32'h01);
    step(0, 7'b0000000);
    chk("t0_one_cycle", 32'(t_fire), 0);
    step(0, 7'b0101100);
    chk("t2_t3_together", 32'(t_fire), 32'h0c);
    step(0, 0);
    step(0, 7'b0010000);
    chk("t4_strobe", 32'(t_fire), 32'h10);
    step(0, 0);
    step(0, 7'b1000000);
    chk("t6_strobe", 32'(t_fire), 32'h40);
    step(0, 0);
    chk("count_after_t6", 32'(net_cycle_count), 1);

    // Round robin across two full net cycles with every request held.
    step(1, 0);
    for (int i = 1; i <= 16; i++) begin
      step(0, 7'h7f);
      if (i == 1) chk("rr_first_t0", 32'(t_fire), 32'h01);
      if (i == 3) chk("rr_t2_t3", 32'(t_fire), 32'h0c);
      if (i == 9) chk("rr_second_t1", 32'(t_fire), 32'h02);
      if (i == 11) chk("rr_t2_t5", 32'(t_fire), 32'h24);
    end
    chk("rr_count_two", 32'(net_cycle_count), 2);

    // Illegal marking locks out firing until reset.
    step(1, 0);
    inj = 1;
    step(0, 7'b0000001);
    chk("bad_err_set", 32'(err_marking), 1);
    chk("bad_no_fire", 32'(t_fire), 0);
    inj = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 7'h7f);
      chk("err_blocks_fire", 32'(t_fire), 0);
    end
    chk("err_sticky", 32'(err_marking), 1);
    step(1, 0);
    chk("err_cleared", 32'(err_marking), 0);

    // Watchdog: t6 requested but not enabled.
    for (int i = 0; i < WDOG - 1; i++) step(0, 7'b1000000);
    chk("wdog_not_yet", 32'(deadlock), 0);
    step(0, 7'b1000000);
    chk("wdog_deadlock", 32'(deadlock), 1);
    step(0, 0);
    chk("wdog_sticky", 32'(deadlock), 1);

    // Reset during the t6 strobe cycle.
    step(1, 0);
    step(0, 7'b0000001); step(0, 0);
    step(0, 7'b0001100); step(0, 0);
    step(0, 7'b0010000); step(0, 0);
    step(0, 7'b1000000);
    chk("mid_t6_strobe", 32'(t_fire), 32'h40);
    step(1, 0);
    chk("mid_rst_t_fire", 32'(t_fire), 0);
    chk("mid_rst_count", 32'(net_cycle_count), 0);

    // Random requests, occasional reset and bad-marking glitch.
    step(1, 0);
    for (int i = 0; i < 600; i++) begin
      logic [6:0] rq;
      logic       rr;
      rq = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) rq = 0;
      rr = ($urandom_range(0, 79) == 0);
      inj = ($urandom_range(0, 149) == 0);
      step(rr, rq);
    end
    inj = 0;
    step(1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/efc_transition_scheduler.md
# efc_transition_scheduler

Synchronous transition scheduler for the three-FSM free-choice net (FSM1 places p0/p2/p4/p6, FSM2 places p0/p3/p5/p7, FSM3 places p1/p2/p4/p6). It sits directly upstream of the three Mealy place FSMs. It takes their exported place outputs and environment fire requests, computes which net transitions are enabled, and resolves the t0/t1 free choice round-robin. It then drives registered one-cycle fire strobes onto the FSMs' `tN_` inputs. Transition-barrier inputs of the FSMs are wired at top level and are outside this block.

## Interface
Parameters:
- WDOG_CYCLES, 1024: idle cycles with a pending request before `deadlock` is raised.
- CNT_W, 16: width of `net_cycle_count`.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- f1_p0, f1_p2, f1_p4, f1_p6  in  1 each  FSM1 place outputs.
- f2_p0, f2_p7  in  1 each  FSM2 place outputs. FSM2 does not export p3/p5.
- f3_p1, f3_p2, f3_p4, f3_p6  in  1 each  FSM3 place outputs.
- req_t  in  7  level fire requests, one bit per transition; bit N = tN.
- t_fire  out  7  registered fire strobes; bit N drives `tN_` of every FSM using tN.
- net_cycle_count  out  CNT_W  number of t6 firings, wraps at 2^CNT_W.
- deadlock  out  1  sticky watchdog flag.
- err_marking  out  1  sticky illegal-marking flag.

## Operation
- Enables, evaluated combinationally from the place inputs:
  - en0 = en1 = f1_p0 & f2_p0 & f3_p1
  - en2 = f1_p2 & f3_p2
  - en4 = f1_p4 & f3_p4
  - en3 = f2_in_mid & ~branch
  - en5 = f2_in_mid & branch
  - en6 = f1_p6 & f2_p7 & f3_p6
  - f2_in_mid = ~f2_p0 & ~f2_p7.
- branch register (shadow of the hidden FSM2 choice): set 0 when t0 fires, set 1 when t1 fires, reset 0.
- Candidate set c = req_t & en.
- t0/t1 conflict:
  - If c0 & c1, fire only the transition selected by rr_ptr (0 selects t0), then toggle rr_ptr.
  - If exactly one of them is a candidate, fire it; rr_ptr is unchanged.
- All other candidates are mutually non-conflicting; every candidate fires in the same strobe. Example: t2 and t3 fire together.
- Fire gating: no new strobe is issued while `t_fire` != 0 (settle cycle, because the place inputs are stale), or while `err_marking` = 1.
- Marking check, every cycle while not in reset. `err_marking` sets and holds until reset if any of:
  - FSM1 places are not exactly one-hot;
  - FSM3 places are not exactly one-hot;
  - f2_p0 & f2_p7.
- `net_cycle_count` increments on the cycle `t_fire[6]` is high; it wraps to 0.
- Watchdog:
  - The counter clears on any fire, or when req_t == 0.
  - Otherwise it increments, saturating.
  - When it reaches WDOG_CYCLES, `deadlock` sets and holds until reset. Firing continues normally.
- Requests are not latched. A request dropped before its fire is lost. A request held after firing may fire again once it is re-enabled.

## Timing
- Reset values: `t_fire` = 0, `net_cycle_count` = 0, `deadlock` = 0, `err_marking` = 0, rr_ptr = 0, branch = 0, watchdog = 0.
- Cycle k: candidates are evaluated and the strobe is registered at the end of cycle k.
- Cycle k+1: `t_fire` is high for exactly one cycle; the FSMs advance at the end of k+1.
- Cycle k+2: new places are visible; next evaluation.
- Minimum spacing between strobes is 2 cycles. Request-to-strobe latency is 1 cycle when enabled and not gated.
- Reset asserted mid-strobe: `t_fire` is 0 in the following cycle and all state returns to reset values. The FSMs reset in the same cycle, so no fire is lost or duplicated.
- `err_marking` rises the cycle after a bad marking appears. `t_fire` is forced 0 from that same cycle.

## Test plan
- Reset, marking f1_p0/f2_p0/f3_p1, req_t=7'b0000001 → t_fire=7'b0000001 one cycle after request, then 0; branch=0.
- req_t=7'b0000011 held through two full net cycles (requests for t2..t6 also asserted) → first choice t0, second choice t1 (round-robin); `net_cycle_count`=2.
- After t0 fires (FSM1 p2, FSM2 mid, FSM3 p2), req_t=7'b0001100 → single strobe 7'b0001100; t5 is never fired.
- Bad marking f1_p2 & f1_p4 → `err_marking`=1 the next cycle; all requests ignored until reset.
- WDOG_CYCLES=8, req_t=7'b1000000 with en6=0 → `deadlock`=1 after 8 cycles and stays 1 after the request drops.
- Reset asserted during the strobe cycle of t6 → `t_fire`=0 and `net_cycle_count`=0 next cycle.
